// File: rtl/i2c_pwm_regs.sv
// rtl/i2c_pwm_regs.sv - I2C target register file holding the LED PWM duty values
module i2c_pwm_regs #(
   parameter logic [6:0] ADDR = 7'h42,
   parameter int         NCH  = 8,
   parameter int         PW   = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe,
   output logic [8*NCH-1:0] duty,
   output logic             wr_strobe,
   output logic [PW-1:0]    wr_index,
   output logic             busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
   } state_t;

   localparam logic [8:0] NCH_W = 9'(NCH);

   logic [1:0]    scl_sync, sda_sync;
   logic [2:0]    scl_hist, sda_hist;
   logic          scl_f, sda_f, scl_d, sda_d;
   logic          scl_rise, scl_fall, start_det, stop_det;

   state_t        state_q, state_n;
   logic [7:0]    shift_q, shift_n;
   logic [3:0]    cnt_q, cnt_n;
   logic [PW-1:0] ptr_q, ptr_n;
   logic          rd_q, rd_n;
   logic          oe_n, busy_n, wr_n;
   logic [7:0]    byte_in;
   logic [7:0]    regs [NCH];

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   // Synchronise and majority-filter the bus lines; idle bus is high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_hist <= 3'b111;
         sda_hist <= 3'b111;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl_i};
         sda_sync <= {sda_sync[0], sda_i};
         scl_hist <= {scl_hist[1:0], scl_sync[1]};
         sda_hist <= {sda_hist[1:0], sda_sync[1]};
         scl_f    <= maj3(scl_hist);
         sda_f    <= maj3(sda_hist);
         scl_d    <= scl_f;
         sda_d    <= sda_f;
      end
   end

   assign scl_rise  = scl_f & ~scl_d;
   assign scl_fall  = ~scl_f & scl_d;
   assign start_det = scl_f & scl_d & sda_d & ~sda_f;
   assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
   assign byte_in   = {shift_q[6:0], sda_f};

   // Protocol state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         shift_q   <= 8'h00;
         cnt_q     <= 4'd0;
         ptr_q     <= '0;
         rd_q      <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_index  <= '0;
      end else begin
         state_q   <= state_n;
         shift_q   <= shift_n;
         cnt_q     <= cnt_n;
         ptr_q     <= ptr_n;
         rd_q      <= rd_n;
         sda_oe    <= oe_n;
         busy      <= busy_n;
         wr_strobe <= wr_n;
         if (wr_n) wr_index <= ptr_q;
      end
   end

   // Duty registers, written on the 8th rise of a data byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) regs[k] <= 8'h00;
      end else if (wr_n) begin
         regs[ptr_q] <= byte_in;
      end
   end

   // Next state; START/STOP override everything so aborted bytes leave no trace
   always_comb begin
      state_n = state_q;
      shift_n = shift_q;
      cnt_n   = cnt_q;
      ptr_n   = ptr_q;
      rd_n    = rd_q;
      oe_n    = sda_oe;
      busy_n  = busy;
      wr_n    = 1'b0;
      if (stop_det) begin
         state_n = S_IDLE;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else if (start_det) begin
         state_n = S_ADDR;
         cnt_n   = 4'd0;
         oe_n    = 1'b0;
         busy_n  = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_ADDR: if (scl_rise) begin
               shift_n = byte_in;
               cnt_n   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_n   = 4'd0;
                  rd_n    = sda_f;
                  state_n = (shift_q[6:0] == ADDR) ? S_ADDR_ACK : S_IGNORE;
               end
            end
            // cnt 0: waiting for the fall that opens the ACK slot; cnt 1: ACK driven
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
               if (cnt_q == 4'd0) begin
                  oe_n  = 1'b1;
                  cnt_n = 4'd1;
               end else begin
                  oe_n  = 1'b0;
                  cnt_n = 4'd0;
                  if (state_q == S_ADDR_ACK && rd_q) begin
                     state_n = S_RDATA;
                     shift_n = regs[ptr_q];
                     oe_n    = ~regs[ptr_q][7];
                  end else if (state_q == S_ADDR_ACK) begin
                     state_n = S_PTR;
                  end else begin
                     state_n = S_WDATA;
                  end
               end
            end
            S_PTR: if (scl_rise) begin
               shift_n = byte_in;
               cnt_n   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_n = 4'd0;
                  if ({1'b0, byte_in} < NCH_W) begin
                     ptr_n   = byte_in[PW-1:0];
                     state_n = S_PTR_ACK;
                  end else begin
                     state_n = S_IGNORE;
                  end
               end
            end
            S_WDATA: if (scl_rise) begin
               shift_n = byte_in;
               cnt_n   = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  cnt_n   = 4'd0;
                  wr_n    = 1'b1;
                  ptr_n   = ptr_q + 1'b1;
                  state_n = S_WDATA_ACK;
               end
            end
            // cnt counts bits whose SCL rise has been seen
            S_RDATA: begin
               if (scl_rise) begin
                  cnt_n = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) ptr_n = ptr_q + 1'b1;
               end else if (scl_fall && cnt_q != 4'd0) begin
                  if (cnt_q == 4'd8) begin
                     oe_n    = 1'b0;
                     cnt_n   = 4'd0;
                     state_n = S_RDATA_ACK;
                  end else begin
                     shift_n = {shift_q[6:0], 1'b0};
                     oe_n    = ~shift_q[6];
                  end
               end
            end
            S_RDATA_ACK: begin
               if (scl_rise) begin
                  if (sda_f) state_n = S_IGNORE;
                  else       cnt_n   = 4'd1;
               end else if (scl_fall && cnt_q == 4'd1) begin
                  state_n = S_RDATA;
                  cnt_n   = 4'd0;
                  shift_n = regs[ptr_q];
                  oe_n    = ~regs[ptr_q][7];
               end
            end
            S_IGNORE: oe_n = 1'b0;
            default: begin
               state_n = S_IDLE;
               oe_n    = 1'b0;
            end
         endcase
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_duty
      assign duty[8*k +: 8] = regs[k];
   end

endmodule

// File: tb/tb_i2c_pwm_regs.sv
// tb/tb_i2c_pwm_regs.sv - directed bench for i2c_pwm_regs
module tb_i2c_pwm_regs;
   localparam int H = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl = 1'b1;
   logic        sda_m = 1'b1;
   logic        sda_line;
   logic        sda_oe, wr_strobe, busy;
   logic [63:0] duty;
   logic [2:0]  wr_index;

   int total = 0;
   int bad = 0;
   int n_strobe = 0;
   int n_double = 0;
   int oe_cnt = 0;
   logic prev_strobe = 1'b0;
   logic [2:0] idx_q[$];
   logic [7:0] exp_d [8];

   assign sda_line = sda_m & ~sda_oe;

   i2c_pwm_regs #(.ADDR(7'h42), .NCH(8)) dut (
      .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line),
      .sda_oe(sda_oe), .duty(duty), .wr_strobe(wr_strobe),
      .wr_index(wr_index), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe) begin
         n_strobe++;
         idx_q.push_back(wr_index);
         if (prev_strobe) n_double++;
      end
      prev_strobe = wr_strobe;
      if (sda_oe) oe_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack_exp();
      logic [63:0] p;
      for (int k = 0; k < 8; k++) p[8*k +: 8] = exp_d[k];
      return p;
   endfunction

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wait_clk(H);
      scl = 1'b1;   wait_clk(H);
      sda_m = 1'b0; wait_clk(H);
      scl = 1'b0;   wait_clk(H);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_clk(H);
      scl = 1'b1;   wait_clk(H);
      sda_m = 1'b1; wait_clk(H);
   endtask

   task automatic bus_bit(input logic b, output logic r);
      sda_m = b;  wait_clk(H);
      scl = 1'b1; wait_clk(H);
      r = sda_line; wait_clk(H);
      scl = 1'b0; wait_clk(H);
   endtask

   task automatic wr_byte(input logic [7:0] v, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bus_bit(v[i], r);
      bus_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] v);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, r);
         v[i] = r;
      end
      bus_bit(nack, r);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic       ack, r;
      logic [7:0] v;
      int         s0, o0;
      for (int k = 0; k < 8; k++) exp_d[k] = 8'h00;

      // reset state
      wait_clk(5);
      check("rst_oe", sda_oe, 0);
      check("rst_duty", duty, 64'h0);
      check("rst_busy", busy, 0);
      check("rst_strobe", wr_strobe, 0);
      check("rst_index", wr_index, 0);
      rst = 1'b0;
      wait_clk(20);

      // write burst at pointer 2
      s0 = n_strobe;
      bus_start();
      check("wb_busy", busy, 1);
      wr_byte(8'h84, ack); check("wb_ack_addr", ack, 1);
      wr_byte(8'h02, ack); check("wb_ack_ptr", ack, 1);
      wr_byte(8'h11, ack); check("wb_ack_d0", ack, 1);
      wr_byte(8'h22, ack); check("wb_ack_d1", ack, 1);
      wr_byte(8'h33, ack); check("wb_ack_d2", ack, 1);
      bus_stop();
      wait_clk(2*H);
      exp_d[2] = 8'h11; exp_d[3] = 8'h22; exp_d[4] = 8'h33;
      check("wb_duty", duty, pack_exp());
      check("wb_busy_after", busy, 0);
      check("wb_nstrobe", n_strobe - s0, 3);
      check("wb_idx0", idx_q.pop_front(), 2);
      check("wb_idx1", idx_q.pop_front(), 3);
      check("wb_idx2", idx_q.pop_front(), 4);

      // pointer wrap on write, then read back across the wrap
      bus_start();
      wr_byte(8'h84, ack); check("wr_ack_addr", ack, 1);
      wr_byte(8'h07, ack); check("wr_ack_ptr", ack, 1);
      wr_byte(8'hAA, ack);
      wr_byte(8'hBB, ack);
      wr_byte(8'hCC, ack); check("wr_ack_last", ack, 1);
      bus_stop();
      wait_clk(2*H);
      exp_d[7] = 8'hAA; exp_d[0] = 8'hBB; exp_d[1] = 8'hCC;
      check("wr_duty", duty, pack_exp());
      check("wr_idx0", idx_q.pop_front(), 7);
      check("wr_idx1", idx_q.pop_front(), 0);
      check("wr_idx2", idx_q.pop_front(), 1);
      bus_start();
      wr_byte(8'h84, ack);
      wr_byte(8'h07, ack); check("rd_ack_ptr", ack, 1);
      bus_start();
      wr_byte(8'h85, ack); check("rd_ack_addr", ack, 1);
      rd_byte(1'b0, v); check("rd_b0", v, 8'hAA);
      rd_byte(1'b0, v); check("rd_b1", v, 8'hBB);
      rd_byte(1'b1, v); check("rd_b2", v, 8'hCC);
      wait_clk(H);
      check("rd_release", sda_oe, 0);
      bus_stop();
      wait_clk(2*H);

      // address miss
      s0 = n_strobe; o0 = oe_cnt;
      bus_start();
      wr_byte(8'h90, ack); check("miss_nack", ack, 0);
      wr_byte(8'h00, ack);
      wr_byte(8'hFF, ack);
      bus_stop();
      wait_clk(2*H);
      check("miss_oe", oe_cnt - o0, 0);
      check("miss_strobe", n_strobe - s0, 0);
      check("miss_duty", duty, pack_exp());

      // pointer out of range
      s0 = n_strobe;
      bus_start();
      wr_byte(8'h84, ack); check("bp_ack_addr", ack, 1);
      wr_byte(8'h09, ack); check("bp_nack_ptr", ack, 0);
      wr_byte(8'h55, ack); check("bp_nack_data", ack, 0);
      bus_stop();
      wait_clk(2*H);
      check("bp_strobe", n_strobe - s0, 0);
      check("bp_duty", duty, pack_exp());

      // STOP mid-byte aborts the write; pointer left at 1
      s0 = n_strobe;
      bus_start();
      wr_byte(8'h84, ack);
      wr_byte(8'h01, ack); check("ab_ack_ptr", ack, 1);
      for (int i = 0; i < 4; i++) bus_bit(1'b1, r);
      bus_stop();
      wait_clk(2*H);
      check("ab_strobe", n_strobe - s0, 0);
      check("ab_duty", duty, pack_exp());
      bus_start();
      wr_byte(8'h85, ack); check("ab_ack_rd", ack, 1);
      rd_byte(1'b1, v); check("ab_rd", v, 8'hCC);
      bus_stop();
      wait_clk(2*H);
      check("double_strobe", n_double, 0);

      // reset while the target is pulling SDA low for ACK
      bus_start();
      for (int i = 7; i >= 0; i--) bus_bit(((8'h84 >> i) & 8'h01) != 0, r);
      sda_m = 1'b1; wait_clk(H);
      scl = 1'b1;   wait_clk(H/2);
      check("mr_oe_before", sda_oe, 1);
      #2 rst = 1'b1;
      #1;
      check("mr_oe", sda_oe, 0);
      check("mr_duty", duty, 64'h0);
      check("mr_busy", busy, 0);
      wait_clk(3);
      rst = 1'b0;
      scl = 1'b0; wait_clk(H);
      bus_stop();
      wait_clk(2*H);
      check("mr_busy_after", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
